// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter shared by instruction fetch,
// data load/store and a debug/loader port.
//
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   f_req/f_addr               fetch read request (fetch never writes)
//   f_gnt/f_rvalid/f_rdata     fetch grant pulse, read-valid pulse, held read data
//   d_req/d_we/d_addr/d_wdata  data request fields
//   d_gnt/d_rvalid/d_rdata     data grant, read-valid, held read data
//   g_req/g_we/g_addr/g_wdata  debug request fields
//   g_gnt/g_rvalid/g_rdata     debug grant, read-valid, held read data
//   mem_en/mem_we/mem_addr/mem_wdata  memory access strobe and fields
//   mem_rdata                  memory read data, valid the cycle after a read strobe
//   busy                       high while an access is in flight (ISSUE or RWAIT)
//
// Access sequence: IDLE (arbitrate, latch winner) -> ISSUE (grant + strobe)
// -> RWAIT (reads only; capture mem_rdata) -> IDLE with rvalid high.
// Every output is a flop; the comb processes compute the value each
// output takes after the next edge.
module mem_arbiter #(
    parameter int unsigned AW   = 8,
    parameter int unsigned DW   = 8,
    parameter int unsigned GMAX = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    input  logic          g_req,
    input  logic          g_we,
    input  logic [AW-1:0] g_addr,
    input  logic [DW-1:0] g_wdata,
    output logic          g_gnt,
    output logic          g_rvalid,
    output logic [DW-1:0] g_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    // Streak counter must be able to hold GMAX itself (saturation value).
    localparam int unsigned SW = (GMAX < 1) ? 1 : $clog2(GMAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(GMAX);

    localparam logic [1:0] OWN_F = 2'd0;
    localparam logic [1:0] OWN_D = 2'd1;
    localparam logic [1:0] OWN_G = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RWAIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    // Arbitration result for the current cycle (only acted on in IDLE)
    logic          win_valid;
    logic [1:0]    win_own;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // Latched access
    logic [1:0]    own_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    // Consecutive debug grants, and which of F/D was granted last (1 = D)
    logic [SW-1:0] streak;
    logic          last_d;

    // Next values of the registered outputs
    logic          f_gnt_nxt, d_gnt_nxt, g_gnt_nxt;
    logic          f_rvalid_nxt, d_rvalid_nxt, g_rvalid_nxt;
    logic [DW-1:0] f_rdata_nxt, d_rdata_nxt, g_rdata_nxt;
    logic          mem_en_nxt, mem_we_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [DW-1:0] mem_wdata_nxt;
    logic          busy_nxt;

    logic          fd_pend;
    assign fd_pend = f_req | d_req;

    // State register, access latch, arbitration history and output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            own_q     <= OWN_F;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            streak    <= '0;
            last_d    <= 1'b1;
            f_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            g_gnt     <= 1'b0;
            f_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            g_rvalid  <= 1'b0;
            f_rdata   <= '0;
            d_rdata   <= '0;
            g_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && win_valid) begin
                own_q   <= win_own;
                we_q    <= win_we;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
                if (win_own == OWN_G) begin
                    if (streak != STREAK_MAX) begin
                        streak <= streak + SW'(1);
                    end
                end else begin
                    streak <= '0;
                    last_d <= (win_own == OWN_D);
                end
            end
            f_gnt     <= f_gnt_nxt;
            d_gnt     <= d_gnt_nxt;
            g_gnt     <= g_gnt_nxt;
            f_rvalid  <= f_rvalid_nxt;
            d_rvalid  <= d_rvalid_nxt;
            g_rvalid  <= g_rvalid_nxt;
            f_rdata   <= f_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            g_rdata   <= g_rdata_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            busy      <= busy_nxt;
        end
    end

    // Winner selection and next state
    always_comb begin
        win_valid = 1'b0;
        win_own   = OWN_F;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        state_nxt = state;

        // Debug wins until its streak hits GMAX, unless nobody else waits.
        if (g_req && ((streak < STREAK_MAX) || !fd_pend)) begin
            win_valid = 1'b1;
            win_own   = OWN_G;
        end else if (f_req && d_req) begin
            win_valid = 1'b1;
            win_own   = last_d ? OWN_F : OWN_D;
        end else if (f_req) begin
            win_valid = 1'b1;
            win_own   = OWN_F;
        end else if (d_req) begin
            win_valid = 1'b1;
            win_own   = OWN_D;
        end

        case (win_own)
            OWN_D: begin
                win_we    = d_we;
                win_addr  = d_addr;
                win_wdata = d_wdata;
            end
            OWN_G: begin
                win_we    = g_we;
                win_addr  = g_addr;
                win_wdata = g_wdata;
            end
            default: begin
                win_we    = 1'b0;
                win_addr  = f_addr;
                win_wdata = '0;
            end
        endcase

        case (state)
            S_IDLE:  if (win_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = we_q ? S_IDLE : S_RWAIT;
            S_RWAIT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next output values: grant and strobe go out in ISSUE, rvalid after RWAIT
    always_comb begin
        f_gnt_nxt     = 1'b0;
        d_gnt_nxt     = 1'b0;
        g_gnt_nxt     = 1'b0;
        f_rvalid_nxt  = 1'b0;
        d_rvalid_nxt  = 1'b0;
        g_rvalid_nxt  = 1'b0;
        f_rdata_nxt   = f_rdata;
        d_rdata_nxt   = d_rdata;
        g_rdata_nxt   = g_rdata;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;
        busy_nxt      = (state_nxt != S_IDLE);

        if (state == S_IDLE && win_valid) begin
            case (win_own)
                OWN_F:   f_gnt_nxt = 1'b1;
                OWN_D:   d_gnt_nxt = 1'b1;
                default: g_gnt_nxt = 1'b1;
            endcase
            mem_en_nxt    = 1'b1;
            mem_we_nxt    = win_we;
            mem_addr_nxt  = win_addr;
            mem_wdata_nxt = win_wdata;
        end

        if (state == S_RWAIT) begin
            case (own_q)
                OWN_F: begin
                    f_rvalid_nxt = 1'b1;
                    f_rdata_nxt  = mem_rdata;
                end
                OWN_D: begin
                    d_rvalid_nxt = 1'b1;
                    d_rdata_nxt  = mem_rdata;
                end
                default: begin
                    g_rvalid_nxt = 1'b1;
                    g_rdata_nxt  = mem_rdata;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned GMAX = 4;

    localparam byte GF = 8'h46;  // 'F'
    localparam byte GD = 8'h44;  // 'D'
    localparam byte GG = 8'h47;  // 'G'

    logic          clk = 1'b0;
    logic          reset;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt, f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          g_req, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          g_gnt, g_rvalid;
    logic [DW-1:0] g_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int  checks = 0;
    int  errors = 0;
    int  drv_cnt = 0;
    byte gq[$];
    logic [DW-1:0] mem [256];

    mem_arbiter #(.AW(AW), .DW(DW), .GMAX(GMAX)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_gnt(g_gnt), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Grant log and one-hot monitors
    always @(negedge clk) begin
        if (f_gnt) gq.push_back(GF);
        if (d_gnt) gq.push_back(GD);
        if (g_gnt) gq.push_back(GG);
        if (f_gnt | d_gnt | g_gnt)
            check("gnt_onehot", 64'($countones({f_gnt, d_gnt, g_gnt})), 64'd1);
        if (f_rvalid | d_rvalid | g_rvalid)
            check("rvalid_onehot", 64'($countones({f_rvalid, d_rvalid, g_rvalid})), 64'd1);
        if (d_rvalid) drv_cnt++;
    end

    function automatic logic [63:0] all_outs();
        return 64'({f_gnt, d_gnt, g_gnt, f_rvalid, d_rvalid, g_rvalid,
                    f_rdata, d_rdata, g_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy});
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check(tag, 64'(busy), 64'd0);
    endtask

    task automatic wait_grants(input int k, input string tag);
        int n;
        n = 0;
        while (gq.size() < k && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (gq.size() < k) check(tag, 64'(gq.size()), 64'(k));
    endtask

    // Each requester drops its request in the cycle it is granted
    task automatic stop_all();
        int n;
        n = 0;
        while ((f_req | d_req | g_req) && n < 300) begin
            @(negedge clk);
            if (f_gnt) f_req = 1'b0;
            if (d_gnt) d_req = 1'b0;
            if (g_gnt) g_req = 1'b0;
            n++;
        end
        if (f_req | d_req | g_req) check("stop_timeout", 64'({f_req, d_req, g_req}), 64'd0);
        wait_idle("stop_idle_timeout");
    endtask

    task automatic check_seq(input string name, input string exp);
        for (int i = 0; i < exp.len(); i++)
            check($sformatf("%s[%0d]", name, i), 64'(gq.size() > i ? gq[i] : 8'h00), 64'(exp[i]));
    endtask

    initial begin
        int n;
        int drv_before;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h03] = 8'hA5;
        mem_rdata = '0;
        reset = 1'b0;
        f_req = 1'b1; f_addr = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        g_req = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;

        // Reset held with requests pending
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        gq.delete();
        reset = 1'b1;
        wait_grants(1, "reset_gnt_timeout");
        check("reset_first_gnt", 64'(gq.size() > 0 ? gq[0] : 8'h00), 64'(GF));
        f_req = 1'b0;
        stop_all();

        // Single fetch read with cycle-exact timing
        f_addr = 8'h03; f_req = 1'b1;
        @(negedge clk);
        check("fetch_gnt", 64'({f_gnt, d_gnt, g_gnt}), 64'b100);
        check("fetch_mem", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b0, 8'h03}));
        check("fetch_busy1", 64'(busy), 64'd1);
        f_req = 1'b0;
        @(negedge clk);
        check("fetch_c2", 64'({f_rvalid, busy, mem_en}), 64'b010);
        @(negedge clk);
        check("fetch_rvalid", 64'({f_rvalid, busy}), 64'b10);
        check("fetch_rdata", 64'(f_rdata), 64'hA5);
        @(negedge clk);
        check("fetch_hold", 64'({f_rvalid, f_rdata}), 64'({1'b0, 8'hA5}));

        // Data write then read back
        d_we = 1'b1; d_addr = 8'h05; d_wdata = 8'h3C; d_req = 1'b1;
        @(negedge clk);
        check("dwr_gnt", 64'({f_gnt, d_gnt, g_gnt}), 64'b010);
        check("dwr_mem", 64'({mem_en, mem_we, mem_addr, mem_wdata}),
              64'({1'b1, 1'b1, 8'h05, 8'h3C}));
        d_req = 1'b0;
        @(negedge clk);
        check("dwr_done", 64'({d_rvalid, busy}), 64'b00);
        d_we = 1'b0; d_wdata = '0; d_req = 1'b1;
        @(negedge clk);
        check("drd_gnt", 64'({d_gnt, mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b1, 1'b0, 8'h05}));
        d_req = 1'b0;
        @(negedge clk);
        check("drd_c2", 64'(d_rvalid), 64'd0);
        @(negedge clk);
        check("drd_rvalid", 64'({d_rvalid, d_rdata}), 64'({1'b1, 8'h3C}));

        // Round-robin between fetch and data
        gq.delete();
        f_addr = 8'h10; d_addr = 8'h11;
        f_req = 1'b1; d_req = 1'b1;
        wait_grants(6, "rr_timeout");
        check_seq("rr", "FDFDFD");
        stop_all();

        // Debug starvation bound
        gq.delete();
        g_addr = 8'h20; g_we = 1'b0;
        g_req = 1'b1; f_req = 1'b1; d_req = 1'b1;
        wait_grants(10, "starve_timeout");
        check_seq("starve", "GGGGFGGGGD");
        stop_all();

        // Debug alone is never throttled
        gq.delete();
        g_req = 1'b1;
        wait_grants(6, "gonly_timeout");
        g_req = 1'b0;
        check_seq("gonly", "GGGGGG");
        wait_idle("gonly_idle_timeout");

        // Reset during RWAIT of a data read
        d_we = 1'b0; d_addr = 8'h05; d_req = 1'b1;
        @(negedge clk);
        check("rst_dgnt", 64'(d_gnt), 64'd1);
        d_req = 1'b0;
        drv_before = drv_cnt;
        @(negedge clk);
        check("rst_rwait_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_outs", all_outs(), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_drvalid", 64'(drv_cnt), 64'(drv_before));

        // Fetch after reset completes normally
        f_addr = 8'h03; f_req = 1'b1;
        @(negedge clk);
        check("post_fgnt", 64'(f_gnt), 64'd1);
        f_req = 1'b0;
        n = 0;
        while (f_rvalid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("post_fetch_latency", 64'(n), 64'd2);
        check("post_fetch_rdata", 64'(f_rdata), 64'hA5);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
